mips_main_control_fsm: RTL and testbench
========================================

// Module: mips_main_control_fsm
// PURPOSE
//  Multicycle main-control FSM. Decodes the 6-bit opcode from the instruction register and sequences
//  datapath strobes. Produces the 3-bit alu_op code consumed by the downstream funct-level ALU control.
//  Sits between the IR and the datapath/ALU-control in the multicycle MIPS core; handshakes with memory.
// PARAMETERS
//  OP_W      6  opcode width
//  ALUOP_W   3  alu_op width (codes fixed: 000 R-type, 001 LW/add, 010 SW/add, 011 BEQ, 100 BNE, 101 J)
// PORTS
//  clk         in   1        clock, rising edge
//  rst_n       in   1        asynchronous active-low reset
//  opcode      in   OP_W     instr[31:26] from IR; sampled in DECODE
//  zero        in   1        ALU zero flag
//  mem_ready   in   1        memory done; qualifies FETCH/MEM_READ/MEM_WRITE
//  alu_op      out  ALUOP_W  code to ALU control
//  pc_write    out  1        PC load enable (incl. resolved branch)
//  ir_write    out  1        IR load enable
//  iord        out  1        0: address=PC, 1: address=ALUOut
//  mem_read    out  1        memory read strobe
//  mem_write   out  1        memory write strobe
//  reg_write   out  1        register-file write enable
//  reg_dst     out  1        1: rd, 0: rt
//  mem_to_reg  out  1        1: MDR, 0: ALUOut
//  alu_src_a   out  1        0: PC, 1: rs
//  alu_src_b   out  2        00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  pc_src      out  2        00 ALU result, 01 ALUOut, 10 jump target
//  illegal     out  1        one-cycle pulse on unsupported opcode
// BEHAVIOUR
//  Moore outputs decoded from state and op_q; all outputs unlisted for a state are 0.
//  States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, BRANCH, JUMP.
//  Reset (async, rst_n=0): state=IDLE, op_q=0; all outputs 0, alu_op=000. IDLE -> FETCH next edge.
//  FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=001, pc_src=00.
//   ir_write=pc_write=mem_ready. Stay while !mem_ready; -> DECODE when mem_ready.
//  DECODE: op_q<=opcode; alu_src_a=0, alu_src_b=11, alu_op=001. Next state from opcode:
//   000000 -> R_EXEC; 100011/101011 -> MEM_ADDR; 000100/000101 -> BRANCH; 000010 -> JUMP;
//   otherwise illegal=1 this cycle, -> FETCH.
//  MEM_ADDR: alu_src_a=1, alu_src_b=10; alu_op=001 (LW) / 010 (SW). -> MEM_READ (LW) / MEM_WRITE (SW).
//  MEM_READ: mem_read=1, iord=1, alu_op=001. Hold while !mem_ready; -> MEM_WB.
//  MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, alu_op=001. -> FETCH.
//  MEM_WRITE: mem_write=1, iord=1, alu_op=010. Hold while !mem_ready; -> FETCH.
//  R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=000. -> R_WB.
//  R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, alu_op=000. -> FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=00, pc_src=01; alu_op=011 (BEQ) / 100 (BNE).
//   pc_write = zero (BEQ) or !zero (BNE), same cycle (combinational on zero). -> FETCH.
//  JUMP: pc_src=10, pc_write=1, alu_op=101. -> FETCH.
//  Latency with mem_ready=1 throughout: R 4, LW 5, SW 4, BEQ/BNE 3, J 3 cycles (FETCH..last state).
//  Each mem_ready low cycle adds one cycle in the waiting state; strobes held stable while waiting.
//  Opcode changes after DECODE are ignored (op_q used). Reset mid-instruction aborts to IDLE;
//   no partial reg_write/mem_write is issued after rst_n falls.
//  Undefined state encodings -> IDLE.
// TESTING
//  1 Reset release, mem_ready=1 -> IDLE 1 cycle, all outputs 0; FETCH next: mem_read=1, ir_write=1.
//  2 opcode=000000 -> states FETCH,DECODE,R_EXEC,R_WB; alu_op 001,001,000,000; reg_write=1 only in R_WB.
//  3 opcode=100011, mem_ready low 2 cycles in MEM_READ -> 7-cycle LW, mem_read held, one reg_write pulse.
//  4 opcode=000100 zero=1 -> pc_write=1 in BRANCH, alu_op=011; opcode=000101 zero=1 -> pc_write=0, alu_op=100.
//  5 opcode=000010 -> JUMP alu_op=101, pc_src=10, pc_write=1; opcode=111111 -> illegal pulse, back to FETCH.
//  6 rst_n low during MEM_WRITE wait -> mem_write drops immediately, state IDLE, no write seen after.

Source files
------------

// File: rtl/mips_main_control_fsm_if.sv
// Control bus between the multicycle main-control FSM and the IR/datapath/memory.
//   opcode, zero, mem_ready : datapath/memory -> FSM
//   alu_op and all strobes  : FSM -> datapath, ALU control, memory
// master = the control FSM, slave = the datapath side.
interface mips_main_control_fsm_if #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
);
  logic [OP_W-1:0]    opcode;
  logic               zero;
  logic               mem_ready;
  logic [ALUOP_W-1:0] alu_op;
  logic               pc_write;
  logic               ir_write;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               reg_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         pc_src;
  logic               illegal;

  modport master (
    input  opcode, zero, mem_ready,
    output alu_op, pc_write, ir_write, iord, mem_read, mem_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, illegal
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  alu_op, pc_write, ir_write, iord, mem_read, mem_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, illegal
  );
endinterface

// File: rtl/mips_main_control_fsm.sv
// Multicycle MIPS main-control FSM.
// Decodes the IR opcode in DECODE, latches it into op_q, and sequences the
// datapath strobes through FETCH / DECODE / execute states. Memory states
// wait on mem_ready with strobes held stable.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (aborts to IDLE, all strobes 0)
//   bus   : control bus (master side) - opcode/zero/mem_ready in,
//           alu_op, pc_write, ir_write, iord, mem_read, mem_write, reg_write,
//           reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, illegal out
module mips_main_control_fsm #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  mips_main_control_fsm_if.master   bus
);

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

  localparam logic [ALUOP_W-1:0] AOP_R   = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] AOP_LW  = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] AOP_SW  = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] AOP_BEQ = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] AOP_BNE = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] AOP_J   = ALUOP_W'(3'b101);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    R_EXEC    = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10
  } state_t;

  state_t          state;
  logic [OP_W-1:0] op_q;

  // Opcode is decoded live in DECODE (for next-state and illegal) and from
  // op_q afterwards, so IR changes past DECODE have no effect.
  logic dec_legal;
  always_comb begin
    dec_legal = 1'b0;
    case (bus.opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: dec_legal = 1'b1;
      default:                                      dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= '0;
    end else begin
      case (state)
        IDLE:      state <= FETCH;
        FETCH:     if (bus.mem_ready) state <= DECODE;
        DECODE: begin
          op_q <= bus.opcode;
          case (bus.opcode)
            OP_RTYPE:      state <= R_EXEC;
            OP_LW, OP_SW:  state <= MEM_ADDR;
            OP_BEQ, OP_BNE: state <= BRANCH;
            OP_J:          state <= JUMP;
            default:       state <= FETCH;
          endcase
        end
        MEM_ADDR:  state <= (op_q == OP_SW) ? MEM_WRITE : MEM_READ;
        MEM_READ:  if (bus.mem_ready) state <= MEM_WB;
        MEM_WB:    state <= FETCH;
        MEM_WRITE: if (bus.mem_ready) state <= FETCH;
        R_EXEC:    state <= R_WB;
        R_WB:      state <= FETCH;
        BRANCH:    state <= FETCH;
        JUMP:      state <= FETCH;
        default:   state <= IDLE;
      endcase
    end
  end

  // Outputs decode from the registered state/op_q. Only pc_write/ir_write in
  // FETCH (mem_ready), pc_write in BRANCH (zero) and illegal in DECODE
  // (opcode) look at live inputs. Because state resets asynchronously, every
  // strobe drops the moment rst_n falls.
  always_comb begin
    bus.alu_op     = AOP_R;
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.pc_src     = 2'b00;
    bus.illegal    = 1'b0;
    case (state)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = AOP_LW;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      DECODE: begin
        // Branch target precomputed here: PC + (imm << 2).
        bus.alu_src_b = 2'b11;
        bus.alu_op    = AOP_LW;
        bus.illegal   = ~dec_legal;
      end
      MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = (op_q == OP_SW) ? AOP_SW : AOP_LW;
      end
      MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        bus.alu_op   = AOP_LW;
      end
      MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.alu_op     = AOP_LW;
      end
      MEM_WRITE: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
        bus.alu_op    = AOP_SW;
      end
      R_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = AOP_R;
      end
      R_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        bus.alu_op    = AOP_R;
      end
      BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.pc_src    = 2'b01;
        if (op_q == OP_BNE) begin
          bus.alu_op   = AOP_BNE;
          bus.pc_write = ~bus.zero;
        end else begin
          bus.alu_op   = AOP_BEQ;
          bus.pc_write = bus.zero;
        end
      end
      JUMP: begin
        bus.pc_src   = 2'b10;
        bus.pc_write = 1'b1;
        bus.alu_op   = AOP_J;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_main_control_fsm.sv
module tb_mips_main_control_fsm;

  logic clk;
  logic rst_n;

  mips_main_control_fsm_if #(.OP_W(6), .ALUOP_W(3)) ctrl ();

  mips_main_control_fsm #(.OP_W(6), .ALUOP_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       illegal;
  } outs_t;

  outs_t obs;
  assign obs = {ctrl.alu_op, ctrl.pc_write, ctrl.ir_write, ctrl.iord, ctrl.mem_read,
                ctrl.mem_write, ctrl.reg_write, ctrl.reg_dst, ctrl.mem_to_reg,
                ctrl.alu_src_a, ctrl.alu_src_b, ctrl.pc_src, ctrl.illegal};

  outs_t exp_q[$];
  string tag_q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  // Expected output vectors per control step.
  function automatic outs_t e_zero();
    outs_t o = '0;
    return o;
  endfunction
  function automatic outs_t e_fetch(input logic rdy);
    outs_t o = '0;
    o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.alu_op = 3'b001;
    o.ir_write = rdy;  o.pc_write  = rdy;
    return o;
  endfunction
  function automatic outs_t e_decode(input logic ill);
    outs_t o = '0;
    o.alu_src_b = 2'b11; o.alu_op = 3'b001; o.illegal = ill;
    return o;
  endfunction
  function automatic outs_t e_memaddr(input logic sw);
    outs_t o = '0;
    o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = sw ? 3'b010 : 3'b001;
    return o;
  endfunction
  function automatic outs_t e_memread();
    outs_t o = '0;
    o.mem_read = 1'b1; o.iord = 1'b1; o.alu_op = 3'b001;
    return o;
  endfunction
  function automatic outs_t e_memwb();
    outs_t o = '0;
    o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.alu_op = 3'b001;
    return o;
  endfunction
  function automatic outs_t e_memwrite();
    outs_t o = '0;
    o.mem_write = 1'b1; o.iord = 1'b1; o.alu_op = 3'b010;
    return o;
  endfunction
  function automatic outs_t e_rexec();
    outs_t o = '0;
    o.alu_src_a = 1'b1; o.alu_op = 3'b000;
    return o;
  endfunction
  function automatic outs_t e_rwb();
    outs_t o = '0;
    o.reg_write = 1'b1; o.reg_dst = 1'b1; o.alu_op = 3'b000;
    return o;
  endfunction
  function automatic outs_t e_branch(input logic bne, input logic taken);
    outs_t o = '0;
    o.alu_src_a = 1'b1; o.pc_src = 2'b01;
    o.alu_op = bne ? 3'b100 : 3'b011; o.pc_write = taken;
    return o;
  endfunction
  function automatic outs_t e_jump();
    outs_t o = '0;
    o.pc_src = 2'b10; o.pc_write = 1'b1; o.alu_op = 3'b101;
    return o;
  endfunction

  task automatic push(input outs_t e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic chk();
    outs_t e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  // One control cycle: expectation queued with the stimulus, compared on the
  // falling edge, inputs for the next cycle changed 1 time unit past rising edge.
  task automatic cyc(input outs_t e, input string tag);
    push(e, tag);
    @(negedge clk);
    chk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    ctrl.opcode    = 6'b000000;
    ctrl.zero      = 1'b0;
    ctrl.mem_ready = 1'b1;
    @(posedge clk); #1;
    cyc(e_zero(), "in_reset");
    rst_n = 1'b1;
    cyc(e_zero(), "idle");

    // R-type
    cyc(e_fetch(1'b1), "r_fetch");
    cyc(e_decode(1'b0), "r_decode");
    cyc(e_rexec(), "r_exec");
    cyc(e_rwb(), "r_wb");

    // LW: FETCH waits once, then MEM_READ waits twice; opcode changes after DECODE
    ctrl.opcode = 6'b100011; ctrl.mem_ready = 1'b0;
    cyc(e_fetch(1'b0), "lw_fetch_wait");
    ctrl.mem_ready = 1'b1;
    cyc(e_fetch(1'b1), "lw_fetch");
    cyc(e_decode(1'b0), "lw_decode");
    ctrl.opcode = 6'b101011;
    cyc(e_memaddr(1'b0), "lw_addr");
    ctrl.mem_ready = 1'b0;
    cyc(e_memread(), "lw_rd_wait0");
    cyc(e_memread(), "lw_rd_wait1");
    ctrl.mem_ready = 1'b1;
    cyc(e_memread(), "lw_rd");
    cyc(e_memwb(), "lw_wb");

    // SW
    cyc(e_fetch(1'b1), "sw_fetch");
    cyc(e_decode(1'b0), "sw_decode");
    cyc(e_memaddr(1'b1), "sw_addr");
    cyc(e_memwrite(), "sw_write");

    // Branches over both zero values
    ctrl.opcode = 6'b000100; ctrl.zero = 1'b1;
    cyc(e_fetch(1'b1), "beq_fetch");
    cyc(e_decode(1'b0), "beq_decode");
    cyc(e_branch(1'b0, 1'b1), "beq_z1_taken");
    ctrl.opcode = 6'b000101;
    cyc(e_fetch(1'b1), "bne_fetch");
    cyc(e_decode(1'b0), "bne_decode");
    cyc(e_branch(1'b1, 1'b0), "bne_z1_not");
    ctrl.opcode = 6'b000100; ctrl.zero = 1'b0;
    cyc(e_fetch(1'b1), "beq2_fetch");
    cyc(e_decode(1'b0), "beq2_decode");
    cyc(e_branch(1'b0, 1'b0), "beq_z0_not");
    ctrl.opcode = 6'b000101;
    cyc(e_fetch(1'b1), "bne2_fetch");
    cyc(e_decode(1'b0), "bne2_decode");
    cyc(e_branch(1'b1, 1'b1), "bne_z0_taken");

    // Jump
    ctrl.opcode = 6'b000010;
    cyc(e_fetch(1'b1), "j_fetch");
    cyc(e_decode(1'b0), "j_decode");
    cyc(e_jump(), "j_jump");

    // Illegal opcode: one-cycle pulse, straight back to FETCH
    ctrl.opcode = 6'b111111;
    cyc(e_fetch(1'b1), "ill_fetch");
    cyc(e_decode(1'b1), "ill_decode");
    ctrl.opcode = 6'b101011;
    cyc(e_fetch(1'b1), "ill_back_fetch");

    // SW interrupted by reset while waiting in MEM_WRITE
    cyc(e_decode(1'b0), "abort_decode");
    cyc(e_memaddr(1'b1), "abort_addr");
    ctrl.mem_ready = 1'b0;
    cyc(e_memwrite(), "abort_wait");
    #1;
    rst_n = 1'b0;
    push(e_zero(), "abort_async");
    #1;
    chk();
    @(posedge clk); #1;
    ctrl.mem_ready = 1'b1;
    cyc(e_zero(), "abort_hold");
    rst_n = 1'b1;
    cyc(e_zero(), "abort_idle");
    cyc(e_fetch(1'b1), "abort_refetch");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
